// File: rtl/race_controller.sv
// Race game sequencer: IDLE -> SETTING -> COUNTDOWN -> RACING <-> PAUSE -> FINISH.
// All outputs are registered; quit aborts to IDLE from any active state.
module race_controller #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int COUNTDOWN_SEC = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_pulse_i,
    input  logic        pause_pulse_i,
    input  logic        quit_pulse_i,
    input  logic        p1_ready_i,
    input  logic        p2_ready_i,
    input  logic        p1_finish_i,
    input  logic        p2_finish_i,
    output logic [2:0]  state_o,
    output logic [2:0]  countdown_val_o,
    output logic [15:0] race_time_o,
    output logic [1:0]  winner_o
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTING   = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd3;
    localparam logic [2:0] ST_RACING    = 3'd4;
    localparam logic [2:0] ST_PAUSE     = 3'd5;
    localparam logic [2:0] ST_FINISH    = 3'd6;

    localparam int SEC_TERM = CLK_FREQ;
    localparam int CS_TERM  = CLK_FREQ / 100;
    localparam int SEC_W    = (SEC_TERM > 1) ? $clog2(SEC_TERM) : 1;
    localparam int CS_W     = (CS_TERM > 1) ? $clog2(CS_TERM) : 1;

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_TERM - 1);
    localparam logic [CS_W-1:0]  CS_LAST  = CS_W'(CS_TERM - 1);
    localparam logic [2:0]       CD_LOAD  = 3'(COUNTDOWN_SEC);

    logic [2:0]       state_q, state_d;
    logic [2:0]       countdown_q, countdown_d;
    logic [15:0]      race_time_q, race_time_d;
    logic [1:0]       winner_q, winner_d;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [CS_W-1:0]  cs_cnt_q, cs_cnt_d;

    logic sec_tick;
    logic cs_tick;
    logic any_finish;

    assign sec_tick   = (sec_cnt_q == SEC_LAST);
    assign cs_tick    = (cs_cnt_q == CS_LAST);
    assign any_finish = p1_finish_i | p2_finish_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            countdown_q <= '0;
            race_time_q <= '0;
            winner_q    <= '0;
            sec_cnt_q   <= '0;
            cs_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            countdown_q <= countdown_d;
            race_time_q <= race_time_d;
            winner_q    <= winner_d;
            sec_cnt_q   <= sec_cnt_d;
            cs_cnt_q    <= cs_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (quit_pulse_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      if (start_pulse_i) state_d = ST_SETTING;
                ST_SETTING:   if (p1_ready_i && p2_ready_i) state_d = ST_COUNTDOWN;
                ST_COUNTDOWN: if (sec_tick && (countdown_q <= 3'd1)) state_d = ST_RACING;
                ST_RACING: begin
                    // finish beats pause when both arrive together
                    if (any_finish)         state_d = ST_FINISH;
                    else if (pause_pulse_i) state_d = ST_PAUSE;
                end
                ST_PAUSE:     if (pause_pulse_i) state_d = ST_RACING;
                ST_FINISH:    if (start_pulse_i) state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        countdown_d = countdown_q;
        race_time_d = race_time_q;
        winner_d    = winner_q;
        sec_cnt_d   = sec_cnt_q;
        cs_cnt_d    = cs_cnt_q;
        if (state_d == ST_IDLE) begin
            countdown_d = '0;
            race_time_d = '0;
            winner_d    = '0;
            sec_cnt_d   = '0;
            cs_cnt_d    = '0;
        end else begin
            case (state_q)
                ST_SETTING: begin
                    if (state_d == ST_COUNTDOWN) begin
                        countdown_d = CD_LOAD;
                        sec_cnt_d   = '0;
                        race_time_d = '0;
                    end
                end
                ST_COUNTDOWN: begin
                    sec_cnt_d = sec_tick ? '0 : sec_cnt_q + SEC_W'(1);
                    if (sec_tick) countdown_d = countdown_q - 3'd1;
                    if (state_d == ST_RACING) cs_cnt_d = '0;
                end
                ST_RACING: begin
                    cs_cnt_d = cs_tick ? '0 : cs_cnt_q + CS_W'(1);
                    if (cs_tick && (race_time_q != 16'hFFFF)) race_time_d = race_time_q + 16'd1;
                    if (state_d == ST_FINISH) winner_d = {p2_finish_i, p1_finish_i};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_o         = state_q;
        countdown_val_o = countdown_q;
        race_time_o     = race_time_q;
        winner_o        = winner_q;
    end

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller at CLK_FREQ=1000, COUNTDOWN_SEC=3.
module tb_race_controller;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_pulse_i, pause_pulse_i, quit_pulse_i;
    logic        p1_ready_i, p2_ready_i, p1_finish_i, p2_finish_i;
    logic [2:0]  state_o;
    logic [2:0]  countdown_val_o;
    logic [15:0] race_time_o;
    logic [1:0]  winner_o;

    int total  = 0;
    int passed = 0;

    race_controller #(.CLK_FREQ(1000), .COUNTDOWN_SEC(3)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_pulse_i   (start_pulse_i),
        .pause_pulse_i   (pause_pulse_i),
        .quit_pulse_i    (quit_pulse_i),
        .p1_ready_i      (p1_ready_i),
        .p2_ready_i      (p2_ready_i),
        .p1_finish_i     (p1_finish_i),
        .p2_finish_i     (p2_finish_i),
        .state_o         (state_o),
        .countdown_val_o (countdown_val_o),
        .race_time_o     (race_time_o),
        .winner_o        (winner_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic pulse_start();
        start_pulse_i = 1'b1;
        tick(1);
        start_pulse_i = 1'b0;
    endtask

    task automatic to_racing(input string tag);
        pulse_start();
        chk({tag, "_setting"}, state_o, 1);
        p1_ready_i = 1'b1;
        p2_ready_i = 1'b1;
        tick(1);
        p1_ready_i = 1'b0;
        p2_ready_i = 1'b0;
        chk({tag, "_cd_state"}, state_o, 3);
        chk({tag, "_cd_load"}, countdown_val_o, 3);
        tick(3000);
        chk({tag, "_racing"}, state_o, 4);
    endtask

    initial begin
        rst_ni = 1'b1;
        {start_pulse_i, pause_pulse_i, quit_pulse_i} = '0;
        {p1_ready_i, p2_ready_i, p1_finish_i, p2_finish_i} = '0;
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_state", state_o, 0);
        chk("rst_cd", countdown_val_o, 0);
        chk("rst_time", race_time_o, 0);
        chk("rst_winner", winner_o, 0);
        tick(2);
        rst_ni = 1'b1;
        tick(2);

        // IDLE ignores everything except start
        quit_pulse_i = 1'b1; pause_pulse_i = 1'b1;
        p1_ready_i = 1'b1; p2_ready_i = 1'b1; p2_finish_i = 1'b1;
        tick(1);
        {quit_pulse_i, pause_pulse_i, p1_ready_i, p2_ready_i, p2_finish_i} = '0;
        chk("idle_ignore", state_o, 0);

        pulse_start();
        chk("idle_to_setting", state_o, 1);
        p1_ready_i = 1'b1;
        tick(3);
        chk("setting_p1_only", state_o, 1);
        p2_ready_i = 1'b1;
        tick(1);
        p1_ready_i = 1'b0; p2_ready_i = 1'b0;
        chk("cd_entry", state_o, 3);
        chk("cd_load", countdown_val_o, 3);
        tick(999);
        chk("cd3_last", countdown_val_o, 3);
        tick(1);
        chk("cd2_first", countdown_val_o, 2);
        // start, pause and finish are ignored while counting down
        start_pulse_i = 1'b1; pause_pulse_i = 1'b1; p1_finish_i = 1'b1;
        tick(1);
        {start_pulse_i, pause_pulse_i, p1_finish_i} = '0;
        tick(998);
        chk("cd2_last_state", state_o, 3);
        chk("cd2_last", countdown_val_o, 2);
        tick(1);
        chk("cd1_first", countdown_val_o, 1);
        tick(999);
        chk("cd1_last_state", state_o, 3);
        tick(1);
        chk("race_entry", state_o, 4);
        chk("race_cd_zero", countdown_val_o, 0);
        chk("race_time0", race_time_o, 0);

        tick(249);
        chk("rt_249", race_time_o, 24);
        tick(1);
        chk("rt_250", race_time_o, 25);
        pause_pulse_i = 1'b1;
        tick(1);
        pause_pulse_i = 1'b0;
        chk("pause_state", state_o, 5);
        p2_finish_i = 1'b1; start_pulse_i = 1'b1;
        tick(1);
        p2_finish_i = 1'b0; start_pulse_i = 1'b0;
        tick(499);
        chk("pause_hold_state", state_o, 5);
        chk("pause_hold_time", race_time_o, 25);
        pause_pulse_i = 1'b1;
        tick(1);
        pause_pulse_i = 1'b0;
        chk("resume_state", state_o, 4);
        tick(100);
        chk("resume_time", race_time_o, 35);

        p2_finish_i = 1'b1;
        tick(1);
        chk("fin_state", state_o, 6);
        chk("fin_winner", winner_o, 2);
        chk("fin_time", race_time_o, 35);
        tick(20);
        p1_finish_i = 1'b1;
        tick(1);
        chk("fin_hold_winner", winner_o, 2);
        chk("fin_hold_time", race_time_o, 35);
        p1_finish_i = 1'b0; p2_finish_i = 1'b0;
        pulse_start();
        chk("fin_to_idle", state_o, 0);
        chk("fin_clr_winner", winner_o, 0);
        chk("fin_clr_time", race_time_o, 0);

        // tie with a simultaneous pause
        to_racing("tie");
        tick(15);
        p1_finish_i = 1'b1; p2_finish_i = 1'b1; pause_pulse_i = 1'b1;
        tick(1);
        {p1_finish_i, p2_finish_i, pause_pulse_i} = '0;
        chk("tie_state", state_o, 6);
        chk("tie_winner", winner_o, 3);
        quit_pulse_i = 1'b1;
        tick(1);
        quit_pulse_i = 1'b0;
        chk("quit_fin_state", state_o, 0);
        chk("quit_fin_winner", winner_o, 0);
        chk("quit_fin_time", race_time_o, 0);

        // quit during countdown
        pulse_start();
        p1_ready_i = 1'b1; p2_ready_i = 1'b1;
        tick(1);
        p1_ready_i = 1'b0; p2_ready_i = 1'b0;
        tick(1000);
        chk("quit_cd_pre", countdown_val_o, 2);
        quit_pulse_i = 1'b1;
        tick(1);
        quit_pulse_i = 1'b0;
        chk("quit_cd_state", state_o, 0);
        chk("quit_cd_val", countdown_val_o, 0);

        // asynchronous reset in the middle of a race
        to_racing("arst");
        tick(55);
        chk("arst_pre_time", race_time_o, 5);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_time", race_time_o, 0);
        chk("arst_cd", countdown_val_o, 0);
        chk("arst_winner", winner_o, 0);
        tick(1);
        rst_ni = 1'b1;
        tick(3);
        chk("arst_release_idle", state_o, 0);
        pulse_start();
        chk("arst_fresh_start", state_o, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/race_controller.md
RACE_CONTROLLER -- requirements
Module: race_controller

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: clock frequency in Hz, integer multiple of 100.
REQ-002 Parameter COUNTDOWN_SEC, default 3: countdown length in seconds, range 1..7.
REQ-003 clk  in  1  system clock; the block SHALL use one clock only.
REQ-004 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start_pulse  in  1  one-cycle, debounced start/confirm button.
REQ-006 pause_pulse  in  1  one-cycle, debounced pause toggle.
REQ-007 quit_pulse  in  1  one-cycle, debounced abort-to-IDLE.
REQ-008 p1_ready, p2_ready  in  1 each  level; player has confirmed car setup.
REQ-009 p1_finish, p2_finish  in  1 each  level; per-car finish flag from each physics engine.
REQ-010 state  out  3  game state broadcast to physics engines and render.
REQ-011 countdown_val  out  3  remaining countdown seconds.
REQ-012 race_time  out  16  elapsed race time in centiseconds.
REQ-013 winner  out  2  0 none, 1 player 1, 2 player 2, 3 tie.

Function
REQ-014 State encoding SHALL be IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6; codes 2 and 7 SHALL never be driven, and an illegal internal value SHALL recover to IDLE on the next clock.
REQ-015 All outputs SHALL be registered; a transition qualified in cycle N SHALL appear on state in cycle N+1.
REQ-016 quit_pulse SHALL have the highest priority: in any state other than IDLE it SHALL force IDLE, with winner=0, race_time=0 and countdown_val=0.
REQ-017 IDLE: start_pulse -> SETTING; all other inputs ignored.
REQ-018 SETTING: p1_ready && p2_ready both high in the same cycle -> COUNTDOWN; countdown_val loaded with COUNTDOWN_SEC, second prescaler cleared, race_time cleared.
REQ-019 COUNTDOWN: second prescaler counts 0..CLK_FREQ-1; on reaching CLK_FREQ-1 it wraps to 0 and countdown_val decrements by 1.
REQ-020 When countdown_val is 1 and a second tick occurs, state SHALL go to RACING and countdown_val to 0; RACING is therefore entered exactly COUNTDOWN_SEC*CLK_FREQ cycles after COUNTDOWN entry.
REQ-021 pause_pulse, start_pulse and the finish inputs SHALL be ignored in COUNTDOWN.
REQ-022 RACING: centisecond prescaler counts 0..CLK_FREQ/100-1, cleared on RACING entry from COUNTDOWN; on each wrap race_time increments by 1 and saturates at 16'hFFFF.
REQ-023 RACING: p1_finish or p2_finish high -> FINISH; winner = {p2_finish, p1_finish} sampled in that cycle (both high = tie, 3).
REQ-024 A finish condition SHALL take priority over pause_pulse in the same cycle.
REQ-025 RACING: pause_pulse with no finish -> PAUSE.
REQ-026 PAUSE: race_time and the centisecond prescaler SHALL hold; pause_pulse -> RACING, and counting resumes from the held prescaler value; finish inputs ignored.
REQ-027 FINISH: race_time, winner and state hold; a later finish of the other car SHALL NOT change winner; start_pulse -> IDLE, clearing winner and race_time.
REQ-028 Prescalers SHALL be sized by $clog2 of their terminal counts; no multipliers or dividers in logic other than parameter constants.

Reset
REQ-029 While rst=0, asynchronously: state=IDLE, countdown_val=0, race_time=0, winner=0, all prescalers=0.
REQ-030 Reset asserted mid-operation (any state) SHALL produce the REQ-029 values immediately; first transition after release requires a fresh qualifying input.

Verification (CLK_FREQ=1000, COUNTDOWN_SEC=3)
REQ-031 start_pulse in IDLE; p1_ready=1, p2_ready=1 -> states 0->1->3; countdown_val 3,2,1 changing every 1000 cycles; state=4, countdown_val=0 exactly 3000 cycles after COUNTDOWN entry.
REQ-032 RACING for 250 cycles -> race_time=25; pause_pulse, hold 500 cycles -> race_time stays 25; pause_pulse again, 100 cycles -> race_time=35.
REQ-033 p2_finish rises alone in RACING -> next cycle state=6, winner=2; p1_finish rises later -> winner stays 2; start_pulse -> state=0, winner=0, race_time=0.
REQ-034 p1_finish, p2_finish and pause_pulse all high in one RACING cycle -> state=6, winner=3.
REQ-035 quit_pulse during COUNTDOWN with countdown_val=2 -> state=0, countdown_val=0 next cycle; pause_pulse during COUNTDOWN -> no effect.
REQ-036 rst=0 asserted during RACING between clock edges -> outputs reach reset values before the next clk edge; only p1_ready high in SETTING -> state stays 1.
